fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the five-stage pipeline. Owns the program counter, drives the instruction-memory read handshake, and produces the `ifid_n` bundle that the pipeline register captures into IF/ID. It also tracks branch/jump redirects that arrive while an instruction fetch is still outstanding, and stops fetching permanently on halt.

## Interface
Parameters:
- `PC_RESET`, default 32'h0000_0000: PC value after reset.
- `CNT_W`, default 32: width of the fetch counter.

Ports:
- `CLK`  in  1  clock. All state changes on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `pipe_stall`  in  `pipe_stall_t`  stall code: NO_STALL, IFID_STALL, IDEX_STALL or FULL_STALL.
- `ihit`  in  1  instruction memory returns `iload` this cycle.
- `iload`  in  32  instruction word. Valid only when `ihit`=1.
- `redirect_en`  in  1  taken branch or jump from EX/MEM.
- `redirect_pc`  in  32  target address. Valid when `redirect_en`=1.
- `halt`  in  1  halt has retired in WB.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  instruction read address.
- `ifid_n`  out  `ifid_t`  next IF/ID contents. Fields driven: `instr[31:0]`, `pc4[31:0]`. All other fields are 0.
- `fetch_count`  out  `CNT_W`  number of instructions accepted into IF/ID.
- `halted`  out  1  the unit is in the HALTED state.

## Operation
- **State registers:** `pc` (32 bits), `pend_pc` (32 bits), `state`, `fetch_count`.
- **States:** FETCH, REDIRECT_PEND, HALTED.
- **FETCH:**
  - Outputs: `imemREN`=1, `imemaddr`=`pc`, `ifid_n.pc4`=`pc`+4.
  - `ifid_n.instr` = `iload` when `ihit`=1 and `redirect_en`=0. Otherwise it is 0, which is a bubble.
  - **Accept:** an accept occurs when `ihit`=1, `redirect_en`=0 and `pipe_stall`==NO_STALL. On an accept, `pc` <= `pc`+4 (mod 2^32) and `fetch_count` increments (wraps at 2^CNT_W).
  - **Stalls:** under IFID_STALL or IDEX_STALL, `pc` holds so the same instruction is fetched again. The pipeline register handles the bubble or hold.
- **Redirect (in FETCH):**
  - Ignored while `pipe_stall`==FULL_STALL. The source holds `redirect_en` stable until the stall clears.
  - `redirect_en`=1 and `ihit`=1: `pc` <= `redirect_pc` and the returned word is dropped.
  - `redirect_en`=1 and `ihit`=0: `pend_pc` <= `redirect_pc` and the state moves to REDIRECT_PEND. This keeps `imemaddr` stable until the outstanding request completes.
  - A redirect never increments `fetch_count`.
- **REDIRECT_PEND:**
  - Outputs: `imemREN`=1, `imemaddr`=`pc`, `ifid_n.instr`=0.
  - On `ihit`=1: the returned word is discarded, `pc` <= `pend_pc`, and the state returns to FETCH.
  - A new `redirect_en` while in this state overwrites `pend_pc`. The last target wins.
- **HALTED:**
  - Outputs: `imemREN`=0, `imemaddr`=`pc`, `ifid_n`=0, `halted`=1.
  - Left only by reset.
- **Halt:** `halt`=1 in any state moves to HALTED on the next edge, with priority over redirect and accept. It is honoured regardless of `pipe_stall`.
- **Reset values:** `pc`=`PC_RESET`, `pend_pc`=0, state FETCH, `fetch_count`=0, `halted`=0. After reset the outputs are `imemREN`=1, `imemaddr`=`PC_RESET` and `ifid_n.instr`=0.
- **Reset mid-operation:** asserting `nRST` during REDIRECT_PEND drops the pending target immediately. Reset is asynchronous, so the outputs take their reset values without waiting for a clock edge.

## Timing
- `ifid_n`, `imemREN` and `imemaddr` are combinational from state and inputs, with no registered latency. IF/ID captures `ifid_n` on the same edge as the accept.
- With `ihit`=1 every cycle and NO_STALL, throughput is 1 instruction per cycle. `pc` advances by 4 on every edge.
- **Redirect latency:**
  - If `ihit`=1 in the redirect cycle: 1 edge. `imemaddr`=`redirect_pc` on the next cycle.
  - If `ihit`=0 in the redirect cycle: the target is issued on the cycle after the completing `ihit`.
- Halt takes 1 edge. `imemREN` is 0 from the next cycle.
- `imemaddr` never changes while a request is outstanding (`imemREN`=1, `ihit`=0), except on reset.

## Test plan
- **Reset then sequential fetch:** release `nRST` with `PC_RESET`=0; hold `ihit`=1, NO_STALL; `iload` is address-dependent. Expect `imemaddr` = 0, 4, 8, 12 on successive cycles, `ifid_n.pc4` = 4, 8, 12, 16, and `fetch_count`=4 after 4 edges.
- **Stall hold:** at `pc`=8, apply IDEX_STALL for 2 cycles, then IFID_STALL for 1 cycle; `ihit`=1. Expect `imemaddr`=8 throughout, `fetch_count` unchanged, then 12 on the cycle after NO_STALL returns.
- **Redirect with hit:** at `pc`=0x10, `ihit`=1, `redirect_en`=1, `redirect_pc`=0x40. Expect `ifid_n.instr`=0 that cycle, `imemaddr`=0x40 next cycle, and no `fetch_count` increment.
- **Redirect during miss:** at `pc`=0x20, `ihit`=0, `redirect_en`=1, `redirect_pc`=0x80, then `ihit`=0 for 3 more cycles.
  - Expect `imemaddr`=0x20 for all 4 cycles and `ifid_n.instr`=0.
  - Expect `imemaddr`=0x80 on the cycle after `ihit` rises.
  - Repeat with a second redirect to 0xC0 in REDIRECT_PEND; expect 0xC0 to be issued.
- **Halt:** assert `halt` during REDIRECT_PEND. Expect `halted`=1, `imemREN`=0 and `ifid_n`=0 from the next cycle, held for 10 cycles despite `redirect_en` and `ihit`.
- **Async reset mid-redirect:** drop `nRST` between edges while in REDIRECT_PEND. Expect `imemaddr`=`PC_RESET`, `fetch_count`=0 and `halted`=0 immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues instruction-memory
// reads, builds the next IF/ID bundle, tracks redirects that land while a
// read is outstanding, and parks in HALTED once halt retires.

package fetch_pkg;
    typedef enum logic [1:0] {
        NO_STALL   = 2'd0,
        IFID_STALL = 2'd1,
        IDEX_STALL = 2'd2,
        FULL_STALL = 2'd3
    } pipe_stall_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  pipe_stall_t      pipe_stall,
    input  logic             ihit,
    input  logic [31:0]      iload,
    input  logic             redirect_en,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic             imemREN,
    output logic [31:0]      imemaddr,
    output ifid_t            ifid_n,
    output logic [CNT_W-1:0] fetch_count,
    output logic             halted
);

    // Instruction-memory handshake: a read is requested in every cycle with
    // imemREN=1 at address imemaddr; it completes in the cycle ihit=1, when
    // iload carries the word. imemaddr is held until that completion, which
    // is why a redirect seen during a miss is parked in pend_pc.

    typedef enum logic [1:0] {
        S_FETCH         = 2'd0,
        S_REDIRECT_PEND = 2'd1,
        S_HALTED        = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [31:0]      pc, next_pc;
    logic [31:0]      pend_pc, next_pend_pc;
    logic [CNT_W-1:0] next_count;

    // State, PC, pending target and fetch counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_FETCH;
            pc          <= PC_RESET;
            pend_pc     <= 32'h0;
            fetch_count <= '0;
        end else begin
            state       <= next_state;
            pc          <= next_pc;
            pend_pc     <= next_pend_pc;
            fetch_count <= next_count;
        end
    end

    // Next-state logic and combinational fetch outputs.
    always_comb begin
        next_state   = state;
        next_pc      = pc;
        next_pend_pc = pend_pc;
        next_count   = fetch_count;
        imemREN      = 1'b1;
        imemaddr     = pc;
        ifid_n       = '0;

        case (state)
            S_FETCH: begin
                ifid_n.pc4 = pc + 32'd4;
                if (ihit && !redirect_en) begin
                    ifid_n.instr = iload;
                end
                // A redirect under FULL_STALL is held by its source, so it
                // is simply picked up once the stall clears.
                if (redirect_en && pipe_stall != FULL_STALL) begin
                    if (ihit) begin
                        next_pc = redirect_pc;
                    end else begin
                        next_pend_pc = redirect_pc;
                        next_state   = S_REDIRECT_PEND;
                    end
                end else if (ihit && !redirect_en && pipe_stall == NO_STALL) begin
                    next_pc    = pc + 32'd4;
                    next_count = fetch_count + CNT_W'(1);
                end
            end
            S_REDIRECT_PEND: begin
                ifid_n.pc4 = pc + 32'd4;
                if (redirect_en) begin
                    next_pend_pc = redirect_pc;
                end
                // The stale word is dropped; the newest target wins even if
                // it arrives in the same cycle as the completion.
                if (ihit) begin
                    next_pc    = redirect_en ? redirect_pc : pend_pc;
                    next_state = S_FETCH;
                end
            end
            S_HALTED: begin
                imemREN = 1'b0;
            end
            default: begin
                imemREN    = 1'b0;
                next_state = S_FETCH;
            end
        endcase

        // Halt overrides any redirect or accept in the same cycle.
        if (halt) begin
            next_state   = S_HALTED;
            next_pc      = pc;
            next_pend_pc = pend_pc;
            next_count   = fetch_count;
        end
    end

    assign halted = (state == S_HALTED);

endmodule
